// File: rtl/mac_acc_signed.sv
// mac_acc_signed: sums a programmed number of signed products, with optional saturation
// Ports: clk/clrn (sync active-low reset); start+len begin a run of len products;
// p/p_valid/p_ready product input stream; acc_out/ovf/out_valid/out_ready result
// handshake; busy high whenever not idle.
module mac_acc_signed #(
  parameter int PW  = 16,
  parameter int AW  = 24,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          start,
  input  logic [7:0]    len,
  input  logic [PW-1:0] p,
  input  logic          p_valid,
  output logic          p_ready,
  output logic [AW-1:0] acc_out,
  output logic          ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, sat_val;
  logic [7:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d, ov;
  logic [AW:0]   sum;
  always_comb begin
    // one guard bit: the sum overflows AW bits when the top two bits disagree
    sum     = {acc_q[AW-1], acc_q} + {{(AW+1-PW){p[PW-1]}}, p};
    ov      = sum[AW] ^ sum[AW-1];
    sat_val = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = len;
        state_d = (len == 8'd0) ? DONE : ACC;
      end
      ACC: if (p_valid) begin
        acc_d   = (ov && SAT != 0) ? sat_val : sum[AW-1:0];
        ovf_d   = ovf_q | ov;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? DONE : ACC;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  assign p_ready   = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_mac_acc_signed.sv
// tb_mac_acc_signed: directed checks of mac_acc_signed (default, saturating and wrapping builds)
module tb_mac_acc_signed;
  logic        clk = 1'b0;
  logic        clrn, start, p_valid, out_ready;
  logic [7:0]  len;
  logic [15:0] p;
  logic        d_pr, d_ovf, d_ov, d_busy, s_pr, s_ovf, s_ov, s_busy, w_pr, w_ovf, w_ov, w_busy;
  logic [23:0] d_acc;
  logic [17:0] s_acc, w_acc;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mac_acc_signed u_def (.clk(clk), .clrn(clrn), .start(start), .len(len), .p(p),
    .p_valid(p_valid), .p_ready(d_pr), .acc_out(d_acc), .ovf(d_ovf), .out_valid(d_ov),
    .out_ready(out_ready), .busy(d_busy));
  mac_acc_signed #(.AW(18), .SAT(1)) u_sat (.clk(clk), .clrn(clrn), .start(start), .len(len),
    .p(p), .p_valid(p_valid), .p_ready(s_pr), .acc_out(s_acc), .ovf(s_ovf), .out_valid(s_ov),
    .out_ready(out_ready), .busy(s_busy));
  mac_acc_signed #(.AW(18), .SAT(0)) u_wrap (.clk(clk), .clrn(clrn), .start(start), .len(len),
    .p(p), .p_valid(p_valid), .p_ready(w_pr), .acc_out(w_acc), .ovf(w_ovf), .out_valid(w_ov),
    .out_ready(out_ready), .busy(w_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0; start = 1'b0; len = 8'd0; p = '0; p_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_acc", d_acc, 0);
    chk("rst_ovf", d_ovf, 0);
    chk("rst_pready", d_pr, 0);
    chk("rst_ovalid", d_ov, 0);
    chk("rst_busy", d_busy, 0);
    clrn = 1'b1;
    tick();
    chk("idle_busy", d_busy, 0);

    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    chk("basic_pready", d_pr, 1);
    chk("basic_busy", d_busy, 1);
    p_valid = 1'b1;
    p = 16'h0064; tick();
    p = 16'hFF9C; tick();
    chk("basic_mid_acc", d_acc, 0);
    chk("basic_mid_ovalid", d_ov, 0);
    p = 16'h3F01; tick(); p_valid = 1'b0;
    chk("basic_ovalid", d_ov, 1);
    chk("basic_acc", d_acc, 32'h3F01);
    chk("basic_ovf", d_ovf, 0);
    chk("basic_pready_done", d_pr, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("basic_drop", d_ov, 0);
    chk("basic_idle", d_busy, 0);
    chk("basic_hold", d_acc, 32'h3F01);

    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    p = 16'h4000; p_valid = 1'b1; tick(); p_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_acc", d_acc, 32'h4000);
      chk("gap_pready", d_pr, 1);
    end
    p_valid = 1'b1; tick(); p_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ovalid", d_ov, 1);
      chk("bp_acc", d_acc, 32'h8000);
      tick();
    end
    chk("bp_ovalid_end", d_ov, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_drop", d_ov, 0);
    chk("bp_busy", d_busy, 0);

    start = 1'b1; len = 8'd9; tick(); start = 1'b0;
    p = 16'h4000; p_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 6) begin
        chk("sat7_acc", s_acc, 32'h1C000);
        chk("sat7_ovf", s_ovf, 0);
      end
      if (i == 7) begin
        chk("sat8_acc", s_acc, 32'h1FFFF);
        chk("sat8_ovf", s_ovf, 1);
        chk("wrap8_acc", w_acc, 32'h20000);
      end
    end
    p_valid = 1'b0;
    chk("sat_acc", s_acc, 32'h1FFFF);
    chk("sat_ovf", s_ovf, 1);
    chk("sat_ovalid", s_ov, 1);
    chk("wrap_acc", w_acc, 32'h24000);
    chk("wrap_ovf", w_ovf, 1);
    chk("wide_acc", d_acc, 32'h24000);
    chk("wide_ovf", d_ovf, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    start = 1'b1; len = 8'd0; p = 16'h1234; p_valid = 1'b1; tick(); start = 1'b0;
    chk("len0_ovalid", s_ov, 1);
    chk("len0_pready", s_pr, 0);
    chk("len0_acc", s_acc, 0);
    chk("len0_ovf", s_ovf, 0);
    tick();
    chk("len0_acc_hold", s_acc, 0);
    chk("len0_pready2", s_pr, 0);
    p_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("len0_idle", s_busy, 0);

    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    p = 16'h0010; p_valid = 1'b1; tick(); tick(); p_valid = 1'b0;
    chk("abort_acc2", d_acc, 32'h20);
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    chk("ign_start_busy", d_busy, 1);
    chk("ign_start_pready", d_pr, 1);
    chk("ign_start_ovalid", d_ov, 0);
    p_valid = 1'b1; tick(); p_valid = 1'b0;
    chk("ign_start_cnt", d_pr, 1);
    chk("ign_start_acc", d_acc, 32'h30);
    clrn = 1'b0; tick(); clrn = 1'b1;
    chk("abort_acc", d_acc, 0);
    chk("abort_pready", d_pr, 0);
    chk("abort_ovalid", d_ov, 0);
    chk("abort_busy", d_busy, 0);
    tick();
    chk("abort_stay_idle", d_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
